// File: rtl/time_set_ctrl_if.sv
// Signal bundle between the digital clock top level and the time/alarm setting front end.
// The top level (master) drives the keys and running time; the front end (slave) drives load, alarm and blink outputs.
interface time_set_ctrl_if;
    logic       key_mode;
    logic       key_up;
    logic       key_alarm;

    logic [3:0] cur_sec_ge;
    logic [2:0] cur_sec_shi;
    logic [3:0] cur_min_ge;
    logic [2:0] cur_min_shi;
    logic [3:0] cur_hour_ge;
    logic [1:0] cur_hour_shi;

    logic       set_time_finish;
    logic [3:0] set_sec_ge;
    logic [2:0] set_sec_shi;
    logic [3:0] set_min_ge;
    logic [2:0] set_min_shi;
    logic [3:0] set_hour_ge;
    logic [1:0] set_hour_shi;

    logic       clock_en;
    logic [3:0] clock_min_ge;
    logic [2:0] clock_min_shi;
    logic [3:0] clock_hour_ge;
    logic [1:0] clock_hour_shi;

    logic [2:0] blink_sel;
    logic       blink_on;

    modport master (
        output key_mode, key_up, key_alarm,
        output cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi,
        input  set_time_finish,
        input  set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi,
        input  clock_en, clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi,
        input  blink_sel, blink_on
    );

    modport slave (
        input  key_mode, key_up, key_alarm,
        input  cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi,
        output set_time_finish,
        output set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi,
        output clock_en, clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi,
        output blink_sel, blink_on
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Push-button front end for the digital clock: debounces three keys and runs the
// time/alarm edit state machine with BCD field stepping, idle timeout and blink control.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_HALF      = 12_500_000,
    parameter int TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    time_set_ctrl_if.slave bus
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLW = $clog2(BLINK_HALF + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_HALF - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_T_HOUR = 3'd1,
        S_T_MIN  = 3'd2,
        S_T_SEC  = 3'd3,
        S_A_HOUR = 3'd4,
        S_A_MIN  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    // Key vectors are indexed 0 = mode, 1 = up, 2 = alarm.
    logic [2:0]     w_keyRaw;
    logic [2:0]     r_sync1;
    logic [2:0]     r_sync2;
    logic [2:0]     r_stable;
    logic [2:0]     r_stableD;
    logic [2:0]     r_press;
    logic [DBW-1:0] r_dbCnt [3];

    logic w_evMode;
    logic w_evUp;
    logic w_evAlarm;
    logic w_anyPress;
    logic w_edit;
    logic w_timeout;

    // Packed BCD fields: hour {shi[1:0], ge[3:0]}, minute/second {shi[2:0], ge[3:0]}.
    logic [5:0] r_eHour,   w_eHour;
    logic [6:0] r_eMin,    w_eMin;
    logic [6:0] r_eSec,    w_eSec;
    logic [5:0] r_setHour, w_setHour;
    logic [6:0] r_setMin,  w_setMin;
    logic [6:0] r_setSec,  w_setSec;
    logic [5:0] r_almHour, w_almHour;
    logic [6:0] r_almMin,  w_almMin;
    logic       r_clockEn, w_clockEn;
    logic       r_setFinish, w_setFinish;

    logic [TOW-1:0] r_idle;
    logic [BLW-1:0] r_blinkCnt;
    logic           r_blinkOn;
    logic [2:0]     r_blinkSel;

    function automatic logic [5:0] incHour(input logic [5:0] hv);
        logic [1:0] shi;
        logic [3:0] ge;
        shi = hv[5:4];
        ge  = hv[3:0];
        if (shi == 2'd2 && ge == 4'd3)
            return 6'd0;
        else if (ge == 4'd9)
            return {shi + 2'd1, 4'd0};
        else
            return {shi, ge + 4'd1};
    endfunction

    function automatic logic [6:0] incMinSec(input logic [6:0] mv);
        logic [2:0] shi;
        logic [3:0] ge;
        shi = mv[6:4];
        ge  = mv[3:0];
        if (ge != 4'd9)
            return {shi, ge + 4'd1};
        else if (shi == 3'd5)
            return 7'd0;
        else
            return {shi + 3'd1, 4'd0};
    endfunction

    function automatic logic [2:0] selFor(input state_t st);
        case (st)
            S_T_HOUR, S_A_HOUR: return 3'b100;
            S_T_MIN,  S_A_MIN:  return 3'b010;
            S_T_SEC:            return 3'b001;
            default:            return 3'b000;
        endcase
    endfunction

    assign w_keyRaw = {bus.key_alarm, bus.key_up, bus.key_mode};

    // Press pulse comes one edge after the stable level falls, so it is fully registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_stable  <= '1;
            r_stableD <= '1;
            r_press   <= '0;
            for (int k = 0; k < 3; k++)
                r_dbCnt[k] <= '0;
        end else begin
            r_sync1   <= w_keyRaw;
            r_sync2   <= r_sync1;
            r_stableD <= r_stable;
            r_press   <= r_stableD & ~r_stable;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] == r_stable[k]) begin
                    r_dbCnt[k] <= '0;
                end else if (r_dbCnt[k] == DB_LAST) begin
                    r_stable[k] <= r_sync2[k];
                    r_dbCnt[k]  <= '0;
                end else begin
                    r_dbCnt[k] <= r_dbCnt[k] + DBW'(1);
                end
            end
        end
    end

    assign w_evMode   = r_press[0];
    assign w_evAlarm  = r_press[2] & ~r_press[0];
    assign w_evUp     = r_press[1] & ~r_press[0] & ~r_press[2];
    assign w_anyPress = |r_press;
    assign w_edit     = (r_state != S_RUN);
    assign w_timeout  = w_edit && !w_anyPress && (r_idle == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_RUN;
        else
            r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_RUN: begin
                if (w_evMode)
                    w_stateNext = S_T_HOUR;
                else if (w_evAlarm)
                    w_stateNext = S_A_HOUR;
            end
            S_T_HOUR: if (w_evMode) w_stateNext = S_T_MIN;
            S_T_MIN:  if (w_evMode) w_stateNext = S_T_SEC;
            S_T_SEC:  if (w_evMode) w_stateNext = S_RUN;
            S_A_HOUR: begin
                if (w_evMode)
                    w_stateNext = S_A_MIN;
                else if (w_evAlarm)
                    w_stateNext = S_RUN;
            end
            S_A_MIN: begin
                if (w_evMode || w_evAlarm)
                    w_stateNext = S_RUN;
            end
            default: w_stateNext = S_RUN;
        endcase
        if (w_timeout)
            w_stateNext = S_RUN;
    end

    // A timeout has no press in its cycle, so none of the edits below can coincide with it.
    always_comb begin
        w_eHour     = r_eHour;
        w_eMin      = r_eMin;
        w_eSec      = r_eSec;
        w_setHour   = r_setHour;
        w_setMin    = r_setMin;
        w_setSec    = r_setSec;
        w_almHour   = r_almHour;
        w_almMin    = r_almMin;
        w_clockEn   = r_clockEn;
        w_setFinish = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_evMode) begin
                    w_eHour = {bus.cur_hour_shi, bus.cur_hour_ge};
                    w_eMin  = {bus.cur_min_shi, bus.cur_min_ge};
                    w_eSec  = {bus.cur_sec_shi, bus.cur_sec_ge};
                end else if (w_evAlarm) begin
                    w_eHour = r_almHour;
                    w_eMin  = r_almMin;
                end
            end
            S_T_HOUR: if (w_evUp) w_eHour = incHour(r_eHour);
            S_T_MIN:  if (w_evUp) w_eMin  = incMinSec(r_eMin);
            S_T_SEC: begin
                if (w_evUp) begin
                    w_eSec = incMinSec(r_eSec);
                end else if (w_evMode) begin
                    w_setHour   = r_eHour;
                    w_setMin    = r_eMin;
                    w_setSec    = r_eSec;
                    w_setFinish = 1'b1;
                end
            end
            S_A_HOUR: begin
                if (w_evUp)
                    w_eHour = incHour(r_eHour);
                else if (w_evAlarm)
                    w_clockEn = 1'b0;
            end
            S_A_MIN: begin
                if (w_evUp) begin
                    w_eMin = incMinSec(r_eMin);
                end else if (w_evMode) begin
                    w_almHour = r_eHour;
                    w_almMin  = r_eMin;
                    w_clockEn = 1'b1;
                end else if (w_evAlarm) begin
                    w_clockEn = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eHour     <= '0;
            r_eMin      <= '0;
            r_eSec      <= '0;
            r_setHour   <= '0;
            r_setMin    <= '0;
            r_setSec    <= '0;
            r_almHour   <= '0;
            r_almMin    <= '0;
            r_clockEn   <= 1'b0;
            r_setFinish <= 1'b0;
        end else begin
            r_eHour     <= w_eHour;
            r_eMin      <= w_eMin;
            r_eSec      <= w_eSec;
            r_setHour   <= w_setHour;
            r_setMin    <= w_setMin;
            r_setSec    <= w_setSec;
            r_almHour   <= w_almHour;
            r_almMin    <= w_almMin;
            r_clockEn   <= w_clockEn;
            r_setFinish <= w_setFinish;
        end
    end

    // Idle and blink counters restart on every state entry; blink_sel follows the next state so it lines up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle     <= '0;
            r_blinkCnt <= '0;
            r_blinkOn  <= 1'b0;
            r_blinkSel <= 3'b000;
        end else begin
            r_blinkSel <= selFor(w_stateNext);
            if (w_stateNext == S_RUN) begin
                r_idle     <= '0;
                r_blinkCnt <= '0;
                r_blinkOn  <= 1'b0;
            end else if (w_stateNext != r_state) begin
                r_idle     <= '0;
                r_blinkCnt <= '0;
                r_blinkOn  <= 1'b1;
            end else begin
                r_idle <= w_anyPress ? '0 : r_idle + TOW'(1);
                if (r_blinkCnt == BL_LAST) begin
                    r_blinkCnt <= '0;
                    r_blinkOn  <= ~r_blinkOn;
                end else begin
                    r_blinkCnt <= r_blinkCnt + BLW'(1);
                end
            end
        end
    end

    assign bus.set_time_finish = r_setFinish;
    assign bus.set_hour_shi    = r_setHour[5:4];
    assign bus.set_hour_ge     = r_setHour[3:0];
    assign bus.set_min_shi     = r_setMin[6:4];
    assign bus.set_min_ge      = r_setMin[3:0];
    assign bus.set_sec_shi     = r_setSec[6:4];
    assign bus.set_sec_ge      = r_setSec[3:0];
    assign bus.clock_en        = r_clockEn;
    assign bus.clock_hour_shi  = r_almHour[5:4];
    assign bus.clock_hour_ge   = r_almHour[3:0];
    assign bus.clock_min_shi   = r_almMin[6:4];
    assign bus.clock_min_ge    = r_almMin[3:0];
    assign bus.blink_sel       = r_blinkSel;
    assign bus.blink_on        = r_blinkOn;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed key sequences, with commit strobes and
// alarm-port changes checked by monitors against queues of hand-computed expectations.
module tb_time_set_ctrl;

   localparam int DEB   = 4;
   localparam int BLINK = 8;
   localparam int TMO   = 200;

   typedef enum logic [2:0] {
      KEY_NONE    = 3'b000,
      KEY_MODE    = 3'b001,
      KEY_UP      = 3'b010,
      KEY_MODE_UP = 3'b011,
      KEY_ALARM   = 3'b100
   } keyMask_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   bit   monOn = 1'b0;

   logic [19:0] setQ[$];
   logic [13:0] alarmQ[$];
   logic [13:0] alarmLast;
   logic [19:0] setNow;
   logic [13:0] alarmNow;

   time_set_ctrl_if bus();

   time_set_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .BLINK_HALF     (BLINK),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Free-running 100 MHz-style clock.
   always #5 clk = ~clk;

   assign setNow   = {bus.set_hour_shi, bus.set_hour_ge, bus.set_min_shi, bus.set_min_ge,
                      bus.set_sec_shi, bus.set_sec_ge};
   assign alarmNow = {bus.clock_en, bus.clock_hour_shi, bus.clock_hour_ge,
                      bus.clock_min_shi, bus.clock_min_ge};

   function automatic logic [19:0] packTime(input int h, input int m, input int s);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [13:0] packAlarm(input bit en, input int h, input int m);
      return {en, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
   endfunction

   // Compares one observed value against a bench-computed expectation.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Presses the keys in the mask together for 'times' clean presses, each held and released long enough to debounce.
   task automatic applyStimulus(input keyMask_t keys, input int times);
      for (int n = 0; n < times; n++) begin
         @(posedge clk); #1;
         bus.key_mode  = ~keys[0];
         bus.key_up    = ~keys[1];
         bus.key_alarm = ~keys[2];
         repeat (8) @(posedge clk);
         #1;
         bus.key_mode  = 1'b1;
         bus.key_up    = 1'b1;
         bus.key_alarm = 1'b1;
         repeat (8) @(posedge clk);
      end
   endtask

   task automatic setCur(input int h, input int m, input int s);
      {bus.cur_hour_shi, bus.cur_hour_ge, bus.cur_min_shi, bus.cur_min_ge,
       bus.cur_sec_shi, bus.cur_sec_ge} = packTime(h, m, s);
   endtask

   // Every load strobe must match the next queued commit; a strobe with nothing queued is an error.
   always @(negedge clk) begin
      if (monOn && rst_n === 1'b1 && bus.set_time_finish === 1'b1) begin
         checks++;
         if (setQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL commit_unexpected: strobe with set=%h, expected no strobe at %0t", setNow, $time);
         end else begin
            logic [19:0] exp;
            exp = setQ.pop_front();
            if (setNow !== exp) begin
               errors++;
               $display("[TB] FAIL commit_value: got %h, expected %h at %0t", setNow, exp, $time);
            end
         end
      end
   end

   // Every change of the alarm port must match the next queued alarm state.
   always @(negedge clk) begin
      if (monOn && alarmNow !== alarmLast) begin
         checks++;
         if (alarmQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL alarm_unexpected: got %h, expected %h at %0t", alarmNow, alarmLast, $time);
         end else begin
            logic [13:0] exp;
            exp = alarmQ.pop_front();
            if (alarmNow !== exp) begin
               errors++;
               $display("[TB] FAIL alarm_value: got %h, expected %h at %0t", alarmNow, exp, $time);
            end
         end
         alarmLast = alarmNow;
      end
   end

   // Hard stop in case the sequence never completes.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n         = 1'b1;
      bus.key_mode  = 1'b1;
      bus.key_up    = 1'b1;
      bus.key_alarm = 1'b1;
      setCur(12, 34, 56);
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_set", 32'(setNow), 32'(0));
      checkOutput("reset_alarm", 32'(alarmNow), 32'(0));
      checkOutput("reset_blink_sel", 32'(bus.blink_sel), 32'(0));
      checkOutput("reset_blink_on", 32'(bus.blink_on), 32'(0));
      checkOutput("reset_finish", 32'(bus.set_time_finish), 32'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      alarmLast = 14'd0;
      monOn     = 1'b1;
      repeat (4) @(posedge clk);

      $display("[TB] set time with wrap to 00:00:00");
      applyStimulus(KEY_MODE, 1);
      @(negedge clk);
      checkOutput("enter_t_hour_sel", 32'(bus.blink_sel), 32'(3'b100));
      applyStimulus(KEY_UP, 12);
      applyStimulus(KEY_MODE, 1);
      @(negedge clk);
      checkOutput("enter_t_min_sel", 32'(bus.blink_sel), 32'(3'b010));
      applyStimulus(KEY_UP, 26);
      applyStimulus(KEY_MODE, 1);
      @(negedge clk);
      checkOutput("enter_t_sec_sel", 32'(bus.blink_sel), 32'(3'b001));
      applyStimulus(KEY_UP, 4);
      setQ.push_back(packTime(0, 0, 0));
      applyStimulus(KEY_MODE, 1);
      @(negedge clk);
      checkOutput("after_commit_sel", 32'(bus.blink_sel), 32'(0));

      $display("[TB] set time to 23:59:59, live time changes ignored");
      applyStimulus(KEY_MODE, 1);
      setCur(1, 2, 3);
      applyStimulus(KEY_UP, 11);
      applyStimulus(KEY_MODE, 1);
      applyStimulus(KEY_UP, 25);
      applyStimulus(KEY_MODE, 1);
      applyStimulus(KEY_UP, 3);
      setQ.push_back(packTime(23, 59, 59));
      applyStimulus(KEY_MODE, 1);

      $display("[TB] debounce glitch and press latency");
      @(posedge clk); #1 bus.key_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.key_mode = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      checkOutput("glitch_no_change", 32'(bus.blink_sel), 32'(0));
      @(posedge clk); #1 bus.key_mode = 1'b0;
      @(posedge clk);
      repeat (DEB + 2) @(posedge clk);
      @(negedge clk);
      checkOutput("latency_not_early", 32'(bus.blink_sel), 32'(0));
      @(posedge clk);
      @(negedge clk);
      checkOutput("latency_exact", 32'(bus.blink_sel), 32'(3'b100));
      checkOutput("blink_on_entry", 32'(bus.blink_on), 32'(1));
      @(posedge clk); #1 bus.key_mode = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checkOutput("blink_on_hold", 32'(bus.blink_on), 32'(1));
      @(posedge clk);
      @(negedge clk);
      checkOutput("blink_on_toggle", 32'(bus.blink_on), 32'(0));
      repeat (8) @(posedge clk);
      applyStimulus(KEY_MODE, 2);
      setQ.push_back(packTime(1, 2, 3));
      applyStimulus(KEY_MODE, 1);

      $display("[TB] set alarm then cancel");
      applyStimulus(KEY_ALARM, 1);
      @(negedge clk);
      checkOutput("enter_a_hour_sel", 32'(bus.blink_sel), 32'(3'b100));
      applyStimulus(KEY_UP, 7);
      applyStimulus(KEY_MODE, 1);
      @(negedge clk);
      checkOutput("enter_a_min_sel", 32'(bus.blink_sel), 32'(3'b010));
      applyStimulus(KEY_UP, 30);
      alarmQ.push_back(packAlarm(1'b1, 7, 30));
      applyStimulus(KEY_MODE, 1);
      @(negedge clk);
      checkOutput("alarm_commit_sel", 32'(bus.blink_sel), 32'(0));
      applyStimulus(KEY_ALARM, 1);
      alarmQ.push_back(packAlarm(1'b0, 7, 30));
      applyStimulus(KEY_ALARM, 1);
      @(negedge clk);
      checkOutput("alarm_cancel_sel", 32'(bus.blink_sel), 32'(0));

      $display("[TB] simultaneous mode and up in T_MIN");
      applyStimulus(KEY_MODE, 2);
      applyStimulus(KEY_MODE_UP, 1);
      @(negedge clk);
      checkOutput("simul_to_t_sec", 32'(bus.blink_sel), 32'(3'b001));
      setQ.push_back(packTime(1, 2, 3));
      applyStimulus(KEY_MODE, 1);

      $display("[TB] idle timeout");
      applyStimulus(KEY_MODE, 1);
      applyStimulus(KEY_UP, 3);
      repeat (150) @(posedge clk);
      @(negedge clk);
      checkOutput("timeout_not_early", 32'(bus.blink_sel), 32'(3'b100));
      repeat (100) @(posedge clk);
      @(negedge clk);
      checkOutput("timeout_sel", 32'(bus.blink_sel), 32'(0));
      checkOutput("timeout_blink_on", 32'(bus.blink_on), 32'(0));
      checkOutput("timeout_set", 32'(setNow), 32'(packTime(1, 2, 3)));

      $display("[TB] asynchronous reset in T_SEC");
      applyStimulus(KEY_MODE, 3);
      @(negedge clk);
      checkOutput("pre_reset_sel", 32'(bus.blink_sel), 32'(3'b001));
      alarmQ.push_back(packAlarm(1'b0, 0, 0));
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_set", 32'(setNow), 32'(0));
      checkOutput("async_reset_alarm", 32'(alarmNow), 32'(0));
      checkOutput("async_reset_sel", 32'(bus.blink_sel), 32'(0));
      checkOutput("async_reset_blink_on", 32'(bus.blink_on), 32'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      setCur(9, 8, 7);
      repeat (4) @(posedge clk);
      applyStimulus(KEY_MODE, 3);
      setQ.push_back(packTime(9, 8, 7));
      applyStimulus(KEY_MODE, 1);

      repeat (20) @(posedge clk);
      @(negedge clk);
      checkOutput("commit_queue_drained", 32'(setQ.size()), 32'(0));
      checkOutput("alarm_queue_drained", 32'(alarmQ.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
